bus_response_ctrl: RTL

Slave-side response controller for the core's memory-mapped data bus. It takes the one-hot slave select vector produced by the address decoder, issues the access to the selected slave, and waits for that slave's ready. It then returns read data and a completion or error strobe to the CPU load/store unit. Unmapped, multiply-selected and timed-out accesses complete with an error, so the bus can never hang.

---
 rtl/bus_response_ctrl_if.sv | 32 +++
 rtl/bus_response_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bus_response_ctrl_if.sv
// Bundles the CPU-side request/response and the slave-side request/ready/data signals
// of the memory-mapped data bus. The slave modport is the response controller's view.
interface bus_response_ctrl_if #(
  parameter int unsigned NUM_SLAVES = 5,
  parameter int unsigned DATA_W     = 32
);

  // CPU load/store unit side
  logic                         m_req;
  logic                         m_we;
  logic [NUM_SLAVES-1:0]        sel;
  logic                         m_ready;
  logic                         m_err;
  logic [DATA_W-1:0]            m_rdata;

  // Slave side
  logic [NUM_SLAVES-1:0]        s_req;
  logic                         s_we;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]        s_ready;

  modport slave (
    input  m_req, m_we, sel, s_rdata, s_ready,
    output m_ready, m_err, m_rdata, s_req, s_we
  );

  modport master (
    output m_req, m_we, sel, s_rdata, s_ready,
    input  m_ready, m_err, m_rdata, s_req, s_we
  );

endinterface

// File: rtl/bus_response_ctrl.sv
// Slave-side response controller: issues a one-hot-selected access, waits for the slave's
// ready with a bounded timeout, and returns read data plus a completion/error strobe.
// Unmapped or multiply-selected accesses and timeouts complete with an error.
module bus_response_ctrl #(
  parameter int unsigned NUM_SLAVES = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_response_ctrl_if.slave   bus
);

  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  we_q, we_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic                  sel_onehot;
  logic                  ready_hit;
  logic [DATA_W-1:0]     rdata_sel;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign sel_onehot = (bus.sel != '0) &&
                      ((bus.sel & (bus.sel - NUM_SLAVES'(1))) == '0);

  // Ready from unselected slaves is masked off.
  assign ready_hit = |(bus.s_ready & sel_q);

  // One-hot AND-OR mux of the selected slave's read data slice.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        rdata_sel = rdata_sel | bus.s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic for the IDLE -> WAIT -> RESP access sequence.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (bus.m_req) begin
          if (sel_onehot) begin
            sel_d   = bus.sel;
            we_d    = bus.m_we;
            cnt_d   = '0;
            state_d = StWait;
          end else begin
            // Decode error: no slave is touched, complete immediately.
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = StResp;
          end
        end
      end
      StWait: begin
        // Ready takes priority over a timeout in the same cycle.
        if (ready_hit) begin
          if (!we_q) begin
            rdata_d = rdata_sel;
          end
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode from the state register only, so reset drops them immediately.
  always_comb begin
    bus.m_ready = (state_q == StResp);
    bus.m_err   = (state_q == StResp) & err_q;
    bus.m_rdata = rdata_q;
    bus.s_req   = (state_q == StWait) ? sel_q : '0;
    bus.s_we    = (state_q == StWait) & we_q;
  end

endmodule
